// File: rtl/lsu_mem_port_if.sv
// Request, data-memory and response bundle between the execute stage, the LSU back end and data memory.
interface lsu_mem_port_if #(
  parameter int unsigned TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic             req_is_store;
  logic [2:0]       req_funct3;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [TAG_W-1:0] req_tag;

  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_we;
  logic             mem_re;
  logic [31:0]      mem_rdata;

  logic             resp_valid;
  logic             resp_ready;
  logic [TAG_W-1:0] resp_tag;
  logic [31:0]      resp_data;
  logic             resp_is_store;
  logic [1:0]       resp_err;

  // Environment side: issues requests, models memory, consumes responses
  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_tag,
    output mem_rdata, resp_ready,
    input  req_ready, mem_addr, mem_wdata, mem_we, mem_re,
    input  resp_valid, resp_tag, resp_data, resp_is_store, resp_err
  );

  // LSU side
  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_tag,
    input  mem_rdata, resp_ready,
    output req_ready, mem_addr, mem_wdata, mem_we, mem_re,
    output resp_valid, resp_tag, resp_data, resp_is_store, resp_err
  );
endinterface

// File: rtl/lsu_mem_port.sv
// LSU back end: one request at a time, lane alignment for stores, extension for loads, tagged response.
module lsu_mem_port #(
  parameter int unsigned MEM_BYTES = 16384,
  parameter int unsigned TAG_W     = 4
) (
  input  logic           clk,
  input  logic           rst,
  lsu_mem_port_if.slave  bus
);
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, ACCESS, LOAD_DATA, RESP} state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [2:0]       f3_q, f3_d;
  logic             is_store_q, is_store_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [1:0]       err_q, err_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic             resp_valid_q, resp_valid_d;
  logic             req_ready_q, req_ready_d;
  logic [3:0]       mem_we_q, mem_we_d;
  logic             mem_re_q, mem_re_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;

  logic [1:0]       err_c;
  logic [3:0]       st_we_c;
  logic [31:0]      st_wdata_c;
  logic [31:0]      ld_shift_c;
  logic [15:0]      ld_half_c;
  logic [31:0]      ld_data_c;

  // Request classification and store lane placement from the incoming request
  always_comb begin
    err_c      = 2'b00;
    st_we_c    = 4'b0000;
    st_wdata_c = 32'h0;
    if (bus.req_is_store ? (bus.req_funct3 > 3'b010)
                         : (bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11)) begin
      err_c = 2'b11;
    end else if ((bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                 (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00)) begin
      err_c = 2'b01;
    end else if (bus.req_addr >= MEM_LIMIT) begin
      err_c = 2'b10;
    end
    case (bus.req_funct3[1:0])
      2'b00: begin
        st_we_c    = 4'(4'b0001 << bus.req_addr[1:0]);
        st_wdata_c = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        st_we_c    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata_c = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        st_we_c    = 4'b1111;
        st_wdata_c = bus.req_wdata;
      end
    endcase
  end

  // Load byte/halfword selection and sign/zero extension from the registered read port
  always_comb begin
    ld_shift_c = bus.mem_rdata >> {addr_q[1:0], 3'b000};
    ld_half_c  = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data_c = {{24{ld_shift_c[7]}}, ld_shift_c[7:0]};
      3'b100:  ld_data_c = {24'h0, ld_shift_c[7:0]};
      3'b001:  ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
      3'b101:  ld_data_c = {16'h0, ld_half_c};
      default: ld_data_c = bus.mem_rdata;
    endcase
  end

  // Next-state and registered-output values; memory strobes are single-cycle pulses in ACCESS
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    f3_d         = f3_q;
    is_store_d   = is_store_q;
    tag_d        = tag_q;
    err_d        = err_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = resp_valid_q;
    req_ready_d  = req_ready_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 4'b0000;
    mem_re_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d      = bus.req_addr;
          f3_d        = bus.req_funct3;
          is_store_d  = bus.req_is_store;
          tag_d       = bus.req_tag;
          err_d       = err_c;
          resp_data_d = 32'h0;
          req_ready_d = 1'b0;
          if (err_c != 2'b00) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
          end else begin
            state_d = ACCESS;
            if (bus.req_is_store) begin
              mem_we_d    = st_we_c;
              mem_wdata_d = st_wdata_c;
            end else begin
              mem_re_d = 1'b1;
            end
          end
        end
      end
      ACCESS: begin
        if (is_store_q) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end else begin
          state_d = LOAD_DATA;
        end
      end
      LOAD_DATA: begin
        resp_data_d  = ld_data_c;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_data_d  = 32'h0;
          req_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset kills any in-flight access at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= 32'h0;
      f3_q         <= 3'b000;
      is_store_q   <= 1'b0;
      tag_q        <= '0;
      err_q        <= 2'b00;
      resp_data_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      req_ready_q  <= 1'b1;
      mem_we_q     <= 4'b0000;
      mem_re_q     <= 1'b0;
      mem_wdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      f3_q         <= f3_d;
      is_store_q   <= is_store_d;
      tag_q        <= tag_d;
      err_q        <= err_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      req_ready_q  <= req_ready_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_re        = mem_re_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_tag      = tag_q;
  assign bus.resp_data     = resp_data_q;
  assign bus.resp_is_store = is_store_q;
  assign bus.resp_err      = err_q;
endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a small byte-enabled, registered-read memory model.
module tb_lsu_mem_port;
  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  lsu_mem_port_if #(.TAG_W(4)) bus ();

  lsu_mem_port #(.MEM_BYTES(16384), .TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 64 words, byte writes, read data registered one cycle after mem_re
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (bus.mem_we[b]) mem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[7:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction; caller sits 1 time unit after a clock edge
  task automatic do_req(input string nm, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [3:0] tg,
                        input int lat, input logic [1:0] er, input logic [31:0] rd,
                        input logic [3:0] xwe, input logic [31:0] xwd, input int hold);
    int          got_lat = 0;
    int          n_we = 0;
    int          n_re = 0;
    logic [3:0]  we_seen = 4'h0;
    logic [31:0] wd_seen = 32'h0;
    bit          ok = (er == 2'b00);
    chk({nm, ".ready"}, 32'(bus.req_ready), 32'h1);
    bus.resp_ready   = (hold == 0);
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_tag      = tg;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 8 && got_lat == 0; c++) begin
      if (bus.mem_we != 4'h0) begin
        n_we++;
        we_seen = bus.mem_we;
        wd_seen = bus.mem_wdata;
      end
      if (bus.mem_re) n_re++;
      if (bus.resp_valid) got_lat = c;
      else begin
        @(posedge clk); #1;
      end
    end
    chk({nm, ".lat"}, 32'(got_lat), 32'(lat));
    chk({nm, ".n_we"}, 32'(n_we), (st && ok) ? 32'h1 : 32'h0);
    chk({nm, ".n_re"}, 32'(n_re), (!st && ok) ? 32'h1 : 32'h0);
    if (st && ok) begin
      chk({nm, ".we"}, 32'(we_seen), 32'(xwe));
      chk({nm, ".wdata"}, wd_seen, xwd);
    end
    chk({nm, ".tag"}, 32'(bus.resp_tag), 32'(tg));
    chk({nm, ".err"}, 32'(bus.resp_err), 32'(er));
    chk({nm, ".data"}, bus.resp_data, rd);
    chk({nm, ".is_st"}, 32'(bus.resp_is_store), 32'(st));
    if (hold > 0) begin
      // Competing request while the response is stalled must not be taken
      bus.req_valid    = 1'b1;
      bus.req_is_store = 1'b1;
      bus.req_funct3   = 3'b010;
      bus.req_addr     = 32'h30;
      bus.req_wdata    = 32'hCAFEF00D;
      bus.req_tag      = 4'h9;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        chk({nm, ".hold_valid"}, 32'(bus.resp_valid), 32'h1);
        chk({nm, ".hold_ready"}, 32'(bus.req_ready), 32'h0);
        chk({nm, ".hold_data"}, bus.resp_data, rd);
        chk({nm, ".hold_tag"}, 32'(bus.resp_tag), 32'(tg));
        chk({nm, ".hold_we"}, 32'(bus.mem_we), 32'h0);
      end
      bus.resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk({nm, ".post_valid"}, 32'(bus.resp_valid), 32'h0);
    chk({nm, ".post_data"}, bus.resp_data, 32'h0);
    chk({nm, ".post_ready"}, 32'(bus.req_ready), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_funct3   = 3'b000;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.req_tag      = 4'h0;
    bus.resp_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req_ready", 32'(bus.req_ready), 32'h1);
    chk("rst.resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst.mem_we", 32'(bus.mem_we), 32'h0);
    chk("rst.mem_re", 32'(bus.mem_re), 32'h0);
    chk("rst.resp_data", bus.resp_data, 32'h0);
    chk("rst.mem_addr", bus.mem_addr, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Stores
    do_req("sw0", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 4'h3, 2, 2'b00, 32'h0, 4'hF, 32'hDEADBEEF, 0);
    chk("sw0.mem", mem[4], 32'hDEADBEEF);
    do_req("sw1", 1'b1, 3'b010, 32'h10, 32'h80FF7F01, 4'h4, 2, 2'b00, 32'h0, 4'hF, 32'h80FF7F01, 0);
    do_req("sb", 1'b1, 3'b000, 32'h21, 32'h000000AB, 4'h5, 2, 2'b00, 32'h0, 4'h2, 32'hABABABAB, 0);
    chk("sb.mem", 32'(mem[8][15:8]), 32'hAB);
    do_req("sh", 1'b1, 3'b001, 32'h22, 32'h00001234, 4'h6, 2, 2'b00, 32'h0, 4'hC, 32'h12341234, 0);
    chk("sh.mem", 32'(mem[8][31:16]), 32'h1234);

    // Loads from word 0x80FF7F01
    do_req("lb", 1'b0, 3'b000, 32'h13, 32'h0, 4'h7, 3, 2'b00, 32'hFFFFFF80, 4'h0, 32'h0, 0);
    do_req("lbu", 1'b0, 3'b100, 32'h13, 32'h0, 4'h8, 3, 2'b00, 32'h00000080, 4'h0, 32'h0, 0);
    do_req("lh", 1'b0, 3'b001, 32'h12, 32'h0, 4'h9, 3, 2'b00, 32'hFFFF80FF, 4'h0, 32'h0, 0);
    do_req("lhu", 1'b0, 3'b101, 32'h10, 32'h0, 4'hA, 3, 2'b00, 32'h00007F01, 4'h0, 32'h0, 0);
    do_req("lb0", 1'b0, 3'b000, 32'h10, 32'h0, 4'hB, 3, 2'b00, 32'h00000001, 4'h0, 32'h0, 0);
    do_req("lw", 1'b0, 3'b010, 32'h10, 32'h0, 4'hC, 3, 2'b00, 32'h80FF7F01, 4'h0, 32'h0, 0);

    // Errors: no memory activity, single-cycle latency
    do_req("e_mis", 1'b0, 3'b010, 32'h6, 32'h0, 4'h1, 1, 2'b01, 32'h0, 4'h0, 32'h0, 0);
    do_req("e_flt", 1'b0, 3'b010, 32'h4000, 32'h0, 4'h2, 1, 2'b10, 32'h0, 4'h0, 32'h0, 0);
    do_req("e_ill", 1'b0, 3'b011, 32'h5, 32'h0, 4'h3, 1, 2'b11, 32'h0, 4'h0, 32'h0, 0);
    do_req("e_sill", 1'b1, 3'b100, 32'h20, 32'h0, 4'hD, 1, 2'b11, 32'h0, 4'h0, 32'h0, 0);
    do_req("e_shmis", 1'b1, 3'b001, 32'h21, 32'h0, 4'hE, 1, 2'b01, 32'h0, 4'h0, 32'h0, 0);
    do_req("e_lflt", 1'b0, 3'b100, 32'h3FFF_FFFF, 32'h0, 4'hF, 1, 2'b10, 32'h0, 4'h0, 32'h0, 0);
    chk("err.mem_intact", mem[4], 32'h80FF7F01);

    // Stalled response, then the next request is accepted normally
    do_req("hold", 1'b0, 3'b010, 32'h10, 32'h0, 4'h7, 3, 2'b00, 32'h80FF7F01, 4'h0, 32'h0, 5);
    do_req("after_hold", 1'b0, 3'b001, 32'h10, 32'h0, 4'h2, 3, 2'b00, 32'h00007F01, 4'h0, 32'h0, 0);

    // Reset during the ACCESS cycle of a store
    do_req("sw_pre", 1'b1, 3'b010, 32'h18, 32'h11111111, 4'h1, 2, 2'b00, 32'h0, 4'hF, 32'h11111111, 0);
    bus.req_valid    = 1'b1;
    bus.req_is_store = 1'b1;
    bus.req_funct3   = 3'b010;
    bus.req_addr     = 32'h18;
    bus.req_wdata    = 32'h55555555;
    bus.req_tag      = 4'h6;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rstmid.we_before", 32'(bus.mem_we), 32'hF);
    rst = 1'b1;
    #1;
    chk("rstmid.we_drop", 32'(bus.mem_we), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rstmid.resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rstmid.req_ready", 32'(bus.req_ready), 32'h1);
    chk("rstmid.mem", mem[6], 32'h11111111);
    do_req("post_rst", 1'b0, 3'b010, 32'h18, 32'h0, 4'h3, 3, 2'b00, 32'h11111111, 4'h0, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
